// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone responder definitions (slave FSM encoding, bus field widths).
// Used by wb_mem_slave, wb_slave_ram and the testbench Wishbone side.
package wb_pkg;

  localparam int WB_SEL_W  = 4;  // byte lanes on a 32-bit bus
  localparam int WB_WAIT_W = 4;  // wait-state counter width (0..15)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_slv_state_t;

endpackage

// File: rtl/wb_slave_ram.sv
// wb_slave_ram: synchronous single-port RAM, 2^DEPTH_W x 32, per-byte write enable,
// registered write-first read (a write returns the merged new word on the same edge).
module wb_slave_ram
  import wb_pkg::*;
#(
  parameter int DEPTH_W = 10
) (
  input  logic                clk,
  input  logic                en,
  input  logic [WB_SEL_W-1:0] be,
  input  logic [DEPTH_W-1:0]  addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata
);

  // NOTE: memory arrays get no reset; clearing thousands of words would need a
  // sequencer, and contents are defined only by what software writes.
  logic [31:0] mem [2**DEPTH_W];
  logic [31:0] merged;

  // Word as it will look after the write: stored lanes overlaid with enabled new lanes.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path infers a latch.
    merged = mem[addr];
    for (int i = 0; i < WB_SEL_W; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  // Byte-lane writes and write-first registered read on the access edge.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < WB_SEL_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= merged;
    end
  end

endmodule

// File: rtl/wb_mem_slave.sv
// wb_mem_slave: Wishbone B4 classic responder in front of an internal word RAM.
// Programmable wait states; one dead RESP cycle per transfer.
// Optional feature macro WB_SLAVE_ERR_EN: out-of-range requests end with wb_err_o
// instead of wb_ack_o; without it the index wraps and every request is acked.
module wb_mem_slave
  import wb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_W     = 10,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic [WB_SEL_W-1:0] wb_sel_i,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]           state;
  logic [WB_WAIT_W-1:0] cnt;

  // Request captured in IDLE, replayed to the RAM when the wait states run out.
  logic                 cap_we;
  logic [DEPTH_W-1:0]   cap_idx;
  logic [DATA_W-1:0]    cap_dat;
  logic [WB_SEL_W-1:0]  cap_sel;
  logic                 cap_ok;

  logic                 ack_q;
  logic                 err_q;

  logic                 req;
  logic [ADDR_W-1:0]    off;
  logic                 live_ok;

  assign req = wb_cyc_i & wb_stb_i;
  assign off = wb_adr_i - BASE_ADDR;

`ifdef WB_SLAVE_ERR_EN
  // Unsigned offset: addresses below BASE_ADDR wrap high and fall out of range.
  assign live_ok  = (off >> (DEPTH_W + 2)) == '0;
  assign wb_err_o = err_q;
  wire unused_off = ^off[1:0];
`else
  assign live_ok  = 1'b1;
  assign wb_err_o = 1'b0;
  wire unused_off = ^{off[ADDR_W-1:DEPTH_W+2], off[1:0], err_q};
`endif

  // The access edge is the one entering RESP. With no wait states that is the
  // capture edge itself, so in IDLE the RAM sees the live bus instead of the capture.
  logic                use_live;
  logic                go;
  logic                acc_we;
  logic                acc_ok;
  logic [DEPTH_W-1:0]  acc_idx;
  logic [DATA_W-1:0]   acc_dat;
  logic [WB_SEL_W-1:0] acc_sel;
  logic [31:0]         ram_rdata;

  assign use_live = (state == ST_IDLE);
  assign go       = (use_live && req && (WAIT_CYCLES == 0))
                  || ((state == ST_WAIT) && wb_cyc_i && (cnt == '0));
  assign acc_we   = use_live ? wb_we_i                : cap_we;
  assign acc_ok   = use_live ? live_ok                : cap_ok;
  assign acc_idx  = use_live ? off[DEPTH_W+1:2]       : cap_idx;
  assign acc_dat  = use_live ? wb_dat_i               : cap_dat;
  assign acc_sel  = use_live ? wb_sel_i               : cap_sel;

  wb_slave_ram #(.DEPTH_W(DEPTH_W)) u_ram (
    .clk   (clk),
    .en    (go),
    .be    ((acc_we && acc_ok) ? acc_sel : '0),
    .addr  (acc_idx),
    .wdata (acc_dat),
    .rdata (ram_rdata)
  );

  // FSM, wait counter, request capture and registered ack/err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cap_we  <= 1'b0;
      cap_idx <= '0;
      cap_dat <= '0;
      cap_sel <= '0;
      cap_ok  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop here samples pre-edge values.
      ack_q <= go & acc_ok;
      err_q <= go & ~acc_ok;
      case (state)
        ST_IDLE: begin
          if (req) begin
            cap_we  <= wb_we_i;
            cap_idx <= off[DEPTH_W+1:2];
            cap_dat <= wb_dat_i;
            cap_sel <= wb_sel_i;
            cap_ok  <= live_ok;
            if (WAIT_CYCLES > 0) begin
              state <= ST_WAIT;
              cnt   <= WB_WAIT_W'(WAIT_CYCLES - 1);
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (!wb_cyc_i)      state <= ST_IDLE;   // initiator abandoned the cycle
          else if (cnt == '0) state <= ST_RESP;
          else                cnt   <= cnt - 1'b1;
        end
        ST_RESP: state <= ST_IDLE;                // dead cycle, bus not sampled
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data is visible only alongside ack; zero otherwise.
  assign wb_ack_o = ack_q;
  assign wb_dat_o = ack_q ? ram_rdata : '0;

endmodule

// File: tb/tb_wb_mem_slave.sv
// tb_wb_mem_slave: scoreboard bench for wb_mem_slave. Three instances share one bus:
// u0 (no wait states), u1 (3 wait states), u2 (2 wait states, BASE_ADDR 0x100).
module tb_wb_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  int          tgt = 0;

  logic [2:0]  cyc_v;
  logic [2:0]  ack_v, err_v;
  logic [31:0] dat_v [3];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_cyc
    assign cyc_v[k] = cyc && (tgt == k);
  end

  wb_mem_slave #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc_v[0]), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_dat_o(dat_v[0]), .wb_ack_o(ack_v[0]), .wb_err_o(err_v[0]));

  wb_mem_slave #(.WAIT_CYCLES(3)) u1 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc_v[1]), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_dat_o(dat_v[1]), .wb_ack_o(ack_v[1]), .wb_err_o(err_v[1]));

  wb_mem_slave #(.WAIT_CYCLES(2), .BASE_ADDR(32'h100)) u2 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc_v[2]), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_dat_o(dat_v[2]), .wb_ack_o(ack_v[2]), .wb_err_o(err_v[2]));

  typedef struct packed {
    logic        chk;   // compare data (reads and error terminations)
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic [7:0]  lat;   // posedges from drive to the termination cycle
  } exp_t;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic        stray; // data without ack, or termination longer than one cycle
    logic [31:0] dat;
    logic [7:0]  lat;
  } resp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        keep;  // hold stb into the next transfer (back-to-back)
    exp_t        e;
  } stim_t;

  exp_t sb[$];

`ifdef WB_SLAVE_ERR_EN
  localparam logic OOR_ERR = 1'b1;
`else
  localparam logic OOR_ERR = 1'b0;
`endif

  function automatic stim_t mk(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                               logic keep, logic ack, logic err, logic chk,
                               logic [31:0] dat, logic [7:0] lat);
    stim_t t;
    t.we = w; t.a = a; t.d = d; t.s = s; t.keep = keep;
    t.e.chk = chk; t.e.ack = ack; t.e.err = err; t.e.dat = dat; t.e.lat = lat;
    return t;
  endfunction

  // Drive one request (called at a negedge) and wait, bounded, for ack or err.
  task automatic xfer(input int k, input stim_t t, output resp_t r);
    int n = 0;
    r = '0;
    tgt = k; cyc = 1'b1; stb = 1'b1;
    we = t.we; adr = t.a; wdat = t.d; sel = t.s;
    forever begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ack_v[k] || err_v[k] || n >= 40) break;
      if (dat_v[k] !== 32'h0) r.stray = 1'b1;
    end
    r.ack = ack_v[k]; r.err = err_v[k]; r.dat = dat_v[k]; r.lat = 8'(n);
    if (!t.keep) begin
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); @(negedge clk);
      if (ack_v[k] || err_v[k] || dat_v[k] !== 32'h0) r.stray = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (ack_v[k] !== 1'b0 || err_v[k] !== 1'b0 || dat_v[k] !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset[u%0d]: ack=%b err=%b dat=%h, required 0 0 00000000",
                 k, ack_v[k], err_v[k], dat_v[k]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    stim_t t[6];
    resp_t r;
    exp_t  e;
    t[0] = mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1, 0, 0, 32'h0,        1);
    t[1] = mk(0, 32'h10, 32'h0,        4'hF, 0, 1, 0, 1, 32'hDEADBEEF, 1);
    t[2] = mk(1, 32'h10, 32'h11223344, 4'h5, 0, 1, 0, 0, 32'h0,        1);
    t[3] = mk(0, 32'h10, 32'h0,        4'h0, 0, 1, 0, 1, 32'hDE22BE44, 1);
    t[4] = mk(1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 1, 0, 0, 32'h0,        1);
    t[5] = mk(0, 32'h10, 32'h0,        4'hF, 0, 1, 0, 1, 32'hDE22BE44, 1);
    foreach (t[i]) begin
      sb.push_back(t[i].e);
      xfer(0, t[i], r);
      e = sb.pop_front();
      tests_run++;
      if (r.ack !== e.ack || r.err !== e.err || r.lat !== e.lat || r.stray
          || (e.chk && r.dat !== e.dat)) begin
        tests_failed++;
        $display("FAIL write_read[%0d]: ack=%b err=%b dat=%h lat=%0d stray=%b, required ack=%b err=%b dat=%h lat=%0d",
                 i, r.ack, r.err, r.dat, r.lat, r.stray, e.ack, e.err, e.dat, e.lat);
      end
    end
  endtask

  task automatic test_out_of_range;
    stim_t t[8];
    int    k[8];
    resp_t r;
    exp_t  e;
    // u0, base 0: 0x1000 is one past the last word.
    k[0] = 0; t[0] = mk(1, 32'h0,    32'h01020304, 4'hF, 0, 1,        0,       0, 32'h0, 1);
    k[1] = 0; t[1] = mk(1, 32'h1000, 32'hCAFEF00D, 4'hF, 0, !OOR_ERR, OOR_ERR, OOR_ERR, 32'h0, 1);
    k[2] = 0; t[2] = mk(0, 32'h0,    32'h0,        4'hF, 0, 1,        0,       1,
                        OOR_ERR ? 32'h01020304 : 32'hCAFEF00D, 1);
    // u2, base 0x100: 0x80 is below base; without the check it wraps to word 0x3E0 (0x1080).
    k[3] = 2; t[3] = mk(1, 32'h1080, 32'h5A5A0001, 4'hF, 0, 1,        0,       0, 32'h0, 3);
    k[4] = 2; t[4] = mk(1, 32'h80,   32'h77778888, 4'hF, 0, !OOR_ERR, OOR_ERR, OOR_ERR, 32'h0, 3);
    k[5] = 2; t[5] = mk(0, 32'h1080, 32'h0,        4'hF, 0, 1,        0,       1,
                        OOR_ERR ? 32'h5A5A0001 : 32'h77778888, 3);
    // Last in-range word of u2.
    k[6] = 2; t[6] = mk(1, 32'h10FC, 32'h600DCAFE, 4'hF, 0, 1,        0,       0, 32'h0, 3);
    k[7] = 2; t[7] = mk(0, 32'h10FC, 32'h0,        4'h3, 0, 1,        0,       1, 32'h600DCAFE, 3);
    foreach (t[i]) begin
      sb.push_back(t[i].e);
      xfer(k[i], t[i], r);
      e = sb.pop_front();
      tests_run++;
      if (r.ack !== e.ack || r.err !== e.err || r.lat !== e.lat || r.stray
          || (e.chk && r.dat !== e.dat)) begin
        tests_failed++;
        $display("FAIL out_of_range[%0d]: ack=%b err=%b dat=%h lat=%0d stray=%b, required ack=%b err=%b dat=%h lat=%0d",
                 i, r.ack, r.err, r.dat, r.lat, r.stray, e.ack, e.err, e.dat, e.lat);
      end
    end
  endtask

  task automatic test_back_to_back;
    stim_t t[8];
    resp_t r;
    exp_t  e;
    for (int i = 0; i < 4; i++) begin
      t[i]   = mk(1, 32'(4*i), 32'h0F0F0000 + 32'(i), 4'hF, 0, 1, 0, 0, 32'h0, 4);
      // First read from IDLE: 1+3 cycles; the following ones pay the dead RESP cycle.
      t[4+i] = mk(0, 32'(4*i), 32'h0, 4'hF, (i < 3), 1, 0, 1,
                  32'h0F0F0000 + 32'(i), (i == 0) ? 8'd4 : 8'd5);
    end
    for (int i = 0; i < 8; i++) sb.push_back(t[i].e);
    for (int i = 0; i < 8; i++) begin
      xfer(1, t[i], r);
      e = sb.pop_front();
      tests_run++;
      if (r.ack !== e.ack || r.err !== e.err || r.lat !== e.lat || r.stray
          || (e.chk && r.dat !== e.dat)) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: ack=%b err=%b dat=%h lat=%0d stray=%b, required ack=%b err=%b dat=%h lat=%0d",
                 i, r.ack, r.err, r.dat, r.lat, r.stray, e.ack, e.err, e.dat, e.lat);
      end
    end
  endtask

  task automatic test_abort;
    stim_t t[2];
    resp_t r;
    exp_t  e;
    logic  seen = 1'b0;
    t[0] = mk(1, 32'h120, 32'hAAAA5555, 4'hF, 0, 1, 0, 0, 32'h0,        3);
    t[1] = mk(0, 32'h120, 32'h0,        4'hF, 0, 1, 0, 1, 32'hAAAA5555, 3);
    sb.push_back(t[0].e);
    xfer(2, t[0], r);
    e = sb.pop_front();
    tests_run++;
    if (r.ack !== e.ack || r.err !== e.err || r.lat !== e.lat || r.stray) begin
      tests_failed++;
      $display("FAIL abort_prewrite: ack=%b err=%b lat=%0d stray=%b, required ack=1 err=0 lat=%0d",
               r.ack, r.err, r.lat, r.stray, e.lat);
    end
    // Write request, then cyc dropped one cycle later while in WAIT.
    tgt = 2; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h120; wdat = 32'h12345678; sel = 4'hF;
    @(posedge clk); @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (ack_v[2] || err_v[2]) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_term: termination seen=%b, required 0", seen);
    end
    sb.push_back(t[1].e);
    xfer(2, t[1], r);
    e = sb.pop_front();
    tests_run++;
    if (r.ack !== e.ack || r.err !== e.err || r.lat !== e.lat || r.stray || r.dat !== e.dat) begin
      tests_failed++;
      $display("FAIL abort_readback: ack=%b err=%b dat=%h lat=%0d stray=%b, required ack=1 err=0 dat=%h lat=%0d",
               r.ack, r.err, r.dat, r.lat, r.stray, e.dat, e.lat);
    end
  endtask

  task automatic test_reset_mid_wait;
    stim_t t[2];
    resp_t r;
    exp_t  e;
    t[0] = mk(1, 32'h40, 32'h11111111, 4'hF, 0, 1, 0, 0, 32'h0,        4);
    t[1] = mk(0, 32'h40, 32'h0,        4'hF, 0, 1, 0, 1, 32'h11111111, 4);
    sb.push_back(t[0].e);
    xfer(1, t[0], r);
    e = sb.pop_front();
    tests_run++;
    if (r.ack !== e.ack || r.err !== e.err || r.lat !== e.lat || r.stray) begin
      tests_failed++;
      $display("FAIL rst_wait_prewrite: ack=%b err=%b lat=%0d stray=%b, required ack=1 err=0 lat=%0d",
               r.ack, r.err, r.lat, r.stray, e.lat);
    end
    // Overwrite attempt, reset two cycles in (still waiting).
    tgt = 1; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; wdat = 32'h99999999; sel = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (ack_v !== 3'b000 || err_v !== 3'b000 || dat_v[1] !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_wait_outputs: ack=%b err=%b dat=%h, required 000 000 00000000",
               ack_v, err_v, dat_v[1]);
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.push_back(t[1].e);
    xfer(1, t[1], r);
    e = sb.pop_front();
    tests_run++;
    if (r.ack !== e.ack || r.err !== e.err || r.lat !== e.lat || r.stray || r.dat !== e.dat) begin
      tests_failed++;
      $display("FAIL rst_wait_readback: ack=%b err=%b dat=%h lat=%0d stray=%b, required ack=1 err=0 dat=%h lat=%0d",
               r.ack, r.err, r.dat, r.lat, r.stray, e.dat, e.lat);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_out_of_range;
    test_back_to_back;
    test_abort;
    test_reset_mid_wait;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
